// File: rtl/sonar_tx_sequencer_if.sv
// Bundle of frame request, BCD payload and serial-transmitter handshake
// signals between the sonar controller and the character sequencer.
interface sonar_tx_sequencer_if;
  logic        start;
  logic [11:0] angulo;
  logic [11:0] medida;
  logic        tx_pronto;
  logic        tx_partida;
  logic [6:0]  tx_dado;
  logic        ocupado;
  logic        fim;
  logic        erro;
  logic [3:0]  db_estado;

  modport master (
    output start, angulo, medida, tx_pronto,
    input  tx_partida, tx_dado, ocupado, fim, erro, db_estado
  );

  modport slave (
    input  start, angulo, medida, tx_pronto,
    output tx_partida, tx_dado, ocupado, fim, erro, db_estado
  );
endinterface

// File: rtl/sonar_tx_sequencer.sv
// Sends one "aaa,mmm#" ASCII frame per start request, one character at a time,
// waiting for the serial transmitter to finish each one or aborting on timeout.
module sonar_tx_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input logic                  clock,
  input logic                  reset,
  sonar_tx_sequencer_if.slave  bus
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] COUNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE = 4'h0,
    LOAD = 4'h1,
    SEND = 4'h2,
    WAIT = 4'h3,
    NEXT = 4'h4,
    DONE = 4'h5,
    ERR  = 4'hF
  } state_t;

  state_t        state, state_next;
  logic [11:0]   angulo_q, medida_q;
  logic [2:0]    index;
  logic [CW-1:0] count;
  logic          timeout;
  logic          tx_partida_c, ocupado_c, fim_c, erro_c;
  logic [6:0]    tx_dado_c;

  function automatic logic [6:0] bcd_ascii(input logic [3:0] nibble);
    return (nibble <= 4'd9) ? (7'h30 + {3'b000, nibble}) : 7'h3F;
  endfunction

  assign timeout = (count == COUNT_LAST);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    tx_partida_c = 1'b0;
    fim_c        = 1'b0;
    erro_c       = 1'b0;
    ocupado_c    = (state != IDLE);
    case (state)
      IDLE: if (bus.start) state_next = LOAD;
      LOAD: state_next = SEND;
      SEND: begin
        tx_partida_c = 1'b1;
        state_next   = WAIT;
      end
      // A completion pulse beats a simultaneous timeout.
      WAIT: begin
        if (bus.tx_pronto)  state_next = NEXT;
        else if (timeout)   state_next = ERR;
      end
      NEXT: state_next = (index == 3'd7) ? DONE : SEND;
      DONE: begin
        fim_c      = 1'b1;
        state_next = IDLE;
      end
      ERR: begin
        erro_c     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The counter saturates at its terminal value so it can never wrap.
  always_ff @(posedge clock) begin
    if (reset) begin
      angulo_q <= 12'h000;
      medida_q <= 12'h000;
      index    <= 3'd0;
      count    <= '0;
    end else begin
      case (state)
        LOAD: begin
          angulo_q <= bus.angulo;
          medida_q <= bus.medida;
          index    <= 3'd0;
          count    <= '0;
        end
        SEND: count <= '0;
        WAIT: if (!bus.tx_pronto && !timeout) count <= count + 1'b1;
        NEXT: if (index != 3'd7) index <= index + 3'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (index)
      3'd0:    tx_dado_c = bcd_ascii(angulo_q[11:8]);
      3'd1:    tx_dado_c = bcd_ascii(angulo_q[7:4]);
      3'd2:    tx_dado_c = bcd_ascii(angulo_q[3:0]);
      3'd3:    tx_dado_c = 7'h2C;
      3'd4:    tx_dado_c = bcd_ascii(medida_q[11:8]);
      3'd5:    tx_dado_c = bcd_ascii(medida_q[7:4]);
      3'd6:    tx_dado_c = bcd_ascii(medida_q[3:0]);
      default: tx_dado_c = 7'h23;
    endcase
  end

  assign bus.tx_partida = tx_partida_c;
  assign bus.tx_dado    = tx_dado_c;
  assign bus.ocupado    = ocupado_c;
  assign bus.fim        = fim_c;
  assign bus.erro       = erro_c;
  assign bus.db_estado  = state;

endmodule

// File: tb/tb_sonar_tx_sequencer.sv
// Randomized self-checking bench: a timeline model predicts when each character
// is started, what it carries, and when the frame ends or aborts.
module tb_sonar_tx_sequencer;

  localparam int TIMEOUT = 10;
  localparam int MAXC    = 256;

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  int   dly[8];

  sonar_tx_sequencer_if bus();

  sonar_tx_sequencer #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not end, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Frame character idx: digits of angulo, comma, digits of medida, hash.
  function automatic logic [6:0] model_char(input logic [11:0] a, input logic [11:0] m, input int idx);
    logic [23:0] digits;
    logic [3:0]  nib;
    int          d;
    digits = {a, m};
    if (idx == 3) return 7'h2C;
    if (idx == 7) return 7'h23;
    d   = (idx < 3) ? idx : idx - 1;
    nib = digits[23 - 4*d -: 4];
    return (nib < 4'd10) ? 7'(48 + int'(nib)) : 7'h3F;
  endfunction

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ocupado"},    32'(bus.ocupado),    32'd0);
    checkOutput({tag, "_tx_partida"}, 32'(bus.tx_partida), 32'd0);
    checkOutput({tag, "_fim"},        32'(bus.fim),        32'd0);
    checkOutput({tag, "_erro"},       32'(bus.erro),       32'd0);
    checkOutput({tag, "_tx_dado"},    32'(bus.tx_dado),    32'h30);
    checkOutput({tag, "_db_estado"},  32'(bus.db_estado),  32'd0);
  endtask

  // dly[i]: WAIT cycle (1..TIMEOUT) on which tx_pronto answers character i;
  // 0 means never, TIMEOUT+1 means one cycle too late.
  task automatic applyStimulus(input logic [11:0] ang, input logic [11:0] med,
                               input bit noise, input int abort_c, input bit hold_start);
    bit         pronto_at[MAXC];
    bit         is_wait[MAXC];
    int         wait_idx[MAXC];
    int         exp_send[8];
    logic [6:0] exp_char[8];
    int         exp_n, last, t, n_before;
    bit         ok;
    int         obs_cyc[$];
    logic [6:0] obs_chr[$];
    int         fim_n, fim_cyc, erro_n, erro_cyc, busy_bad, dado_bad;
    logic       exp_busy;

    for (int c = 0; c < MAXC; c++) begin
      pronto_at[c] = 1'b0;
      is_wait[c]   = 1'b0;
      wait_idx[c]  = 0;
    end
    t = 2; exp_n = 0; ok = 1'b1; last = 0;
    for (int i = 0; i < 8; i++) begin
      exp_send[i] = t;
      exp_char[i] = model_char(ang, med, i);
      exp_n++;
      if (dly[i] >= 1 && dly[i] <= TIMEOUT) begin
        for (int w = 1; w <= dly[i]; w++) begin
          is_wait[t+w]  = 1'b1;
          wait_idx[t+w] = i;
        end
        pronto_at[t+dly[i]] = 1'b1;
        t = t + dly[i] + 2;
      end else begin
        for (int w = 1; w <= TIMEOUT; w++) begin
          is_wait[t+w]  = 1'b1;
          wait_idx[t+w] = i;
        end
        if (dly[i] > TIMEOUT) pronto_at[t+dly[i]] = 1'b1;
        last = t + TIMEOUT + 1;
        ok   = 1'b0;
        break;
      end
    end
    if (ok) last = t;

    fim_n = 0; fim_cyc = -1; erro_n = 0; erro_cyc = -1; busy_bad = 0; dado_bad = 0;
    for (int c = 0; c <= last + 1; c++) begin
      @(negedge clock);
      exp_busy = (c >= 1 && c <= last);
      if (bus.ocupado !== exp_busy) busy_bad++;
      if (bus.tx_partida === 1'b1) begin
        obs_cyc.push_back(c);
        obs_chr.push_back(bus.tx_dado);
      end
      if (is_wait[c] && bus.tx_dado !== exp_char[wait_idx[c]]) dado_bad++;
      if (bus.fim === 1'b1)  begin fim_n++;  fim_cyc = c;  end
      if (bus.erro === 1'b1) begin erro_n++; erro_cyc = c; end
      if (abort_c > 0 && c == abort_c) begin
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.tx_pronto = 1'b0;
        break;
      end
      bus.start = (c == 0) || (hold_start && c >= last) ||
                  (noise && c >= 1 && c < last && $urandom_range(0, 3) == 0);
      bus.tx_pronto = pronto_at[c] || (noise && !is_wait[c] && $urandom_range(0, 3) == 0);
      if (c == 0) begin
        bus.angulo = ang;
        bus.medida = med;
      end else if (noise && c >= 2) begin
        bus.angulo = 12'($urandom);
        bus.medida = 12'($urandom);
      end
    end

    if (abort_c > 0) begin
      n_before = 0;
      for (int i = 0; i < exp_n; i++) if (exp_send[i] <= abort_c) n_before++;
      checkOutput("abort_partida_count", 32'(obs_cyc.size()), 32'(n_before));
      return;
    end

    checkOutput("partida_count", 32'(obs_cyc.size()), 32'(exp_n));
    for (int i = 0; i < obs_cyc.size() && i < exp_n; i++) begin
      checkOutput($sformatf("partida_cycle_%0d", i), 32'(obs_cyc[i]), 32'(exp_send[i]));
      checkOutput($sformatf("char_%0d", i),          32'(obs_chr[i]), 32'(exp_char[i]));
    end
    checkOutput("fim_count",  32'(fim_n),  ok ? 32'd1 : 32'd0);
    checkOutput("erro_count", 32'(erro_n), ok ? 32'd0 : 32'd1);
    if (ok) checkOutput("fim_cycle",  32'(fim_cyc),  32'(last));
    else    checkOutput("erro_cycle", 32'(erro_cyc), 32'(last));
    checkOutput("ocupado_profile", 32'(busy_bad), 32'd0);
    checkOutput("tx_dado_stable",  32'(dado_bad), 32'd0);
    checkOutput("idle_after_frame", 32'(bus.db_estado), 32'd0);

    bus.tx_pronto = 1'b0;
    if (hold_start) begin
      @(negedge clock);
      checkOutput("restart_from_held_start", 32'(bus.db_estado), 32'd1);
    end
    bus.start = 1'b0;
  endtask

  initial begin
    int partida_n, busy_n, r;

    reset = 1'b1;
    bus.start = 1'b0; bus.tx_pronto = 1'b0;
    bus.angulo = 12'h000; bus.medida = 12'h000;
    repeat (2) @(negedge clock);
    checkResetState("reset");
    reset = 1'b0;

    // "090,123#" with immediate responder: 26 cycles LOAD..IDLE.
    for (int i = 0; i < 8; i++) dly[i] = 1;
    applyStimulus(12'h090, 12'h123, 1'b0, 0, 1'b0);

    // Non-BCD nibble plus spurious start / pronto and changing inputs mid-frame.
    applyStimulus(12'h457, 12'h1A5, 1'b1, 0, 1'b0);

    // No answer on first character: abort after TIMEOUT WAIT cycles.
    dly[0] = 0;
    applyStimulus(12'h321, 12'h987, 1'b0, 0, 1'b0);

    // Answer one cycle too late, then exactly on the last allowed cycle.
    dly[0] = TIMEOUT + 1;
    applyStimulus(12'h111, 12'h222, 1'b0, 0, 1'b0);
    for (int i = 0; i < 8; i++) dly[i] = TIMEOUT;
    applyStimulus(12'h999, 12'h000, 1'b1, 0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 8; i++) begin
        r = int'($urandom_range(0, 39));
        if (r == 0)      dly[i] = 0;
        else if (r == 1) dly[i] = TIMEOUT + 1;
        else             dly[i] = int'($urandom_range(1, TIMEOUT));
      end
      applyStimulus(12'($urandom), 12'($urandom), 1'b1, 0, 1'b0);
    end

    // Start held through DONE launches the next frame right after IDLE.
    for (int i = 0; i < 8; i++) dly[i] = 1;
    applyStimulus(12'h180, 12'h400, 1'b0, 0, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    checkResetState("reset_after_restart");
    reset = 1'b0;

    // Reset while waiting on character 4 (SEND at 2+3*4, WAIT one later).
    applyStimulus(12'h246, 12'h802, 1'b0, 2 + 3*4 + 1, 1'b0);
    @(negedge clock);
    checkResetState("reset_mid_frame");
    reset = 1'b0;
    partida_n = 0; busy_n = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      if (bus.tx_partida === 1'b1) partida_n++;
      if (bus.ocupado === 1'b1)    busy_n++;
      bus.tx_pronto = ($urandom_range(0, 1) == 1);
    end
    bus.tx_pronto = 1'b0;
    checkOutput("no_partida_after_reset", 32'(partida_n), 32'd0);
    checkOutput("idle_after_reset",       32'(busy_n),    32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sonar_tx_sequencer.md
SONAR_TX_SEQUENCER -- requirements
Module: sonar_tx_sequencer

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT_CYCLES, default 1_000_000, maximum WAIT-state cycles allowed per character before abort.
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, request to transmit one frame; sampled only in IDLE.
REQ-005 The block SHALL have port angulo, input, 12, three BCD digits of servo angle (hundreds in [11:8]).
REQ-006 The block SHALL have port medida, input, 12, three BCD digits of distance in cm (hundreds in [11:8]).
REQ-007 The block SHALL have port tx_pronto, input, 1, one-cycle pulse from the serial transmitter marking end of a character.
REQ-008 The block SHALL have port tx_partida, output, 1, one-cycle start pulse to the serial transmitter.
REQ-009 The block SHALL have port tx_dado, output, 7, ASCII character presented to the serial transmitter.
REQ-010 The block SHALL have port ocupado, output, 1, high in every state except IDLE.
REQ-011 The block SHALL have port fim, output, 1, one-cycle pulse on successful frame completion.
REQ-012 The block SHALL have port erro, output, 1, one-cycle pulse on timeout abort.
REQ-013 The block SHALL have port db_estado, output, 4, encoding of the current state.

Function
REQ-014 The FSM SHALL have states IDLE=0, LOAD=1, SEND=2, WAIT=3, NEXT=4, DONE=5, ERR=F; db_estado SHALL equal the current state code.
REQ-015 IDLE: start=1 -> LOAD; otherwise remain in IDLE.
REQ-016 LOAD: latch angulo and medida into internal registers; clear character index to 0 and the timeout counter to 0; -> SEND.
REQ-017 Frame order, index 0..7: angulo[11:8], angulo[7:4], angulo[3:0], ',' (0x2C), medida[11:8], medida[7:4], medida[3:0], '#' (0x23).
REQ-018 Digit encoding: nibble 0-9 -> 0x30+nibble; nibble A-F -> '?' (0x3F).
REQ-019 tx_dado SHALL reflect the latched registers only; input changes after LOAD SHALL NOT affect the frame in progress.
REQ-020 SEND: tx_partida=1 for exactly this one cycle; timeout counter cleared; -> WAIT.
REQ-021 tx_dado SHALL be stable from SEND through the end of the following WAIT for the same index.
REQ-022 WAIT: tx_pronto=1 -> NEXT. Otherwise increment the counter; when the counter reaches TIMEOUT_CYCLES-1 without tx_pronto -> ERR.
REQ-023 If tx_pronto and the timeout condition occur in the same cycle, tx_pronto SHALL win and the next state SHALL be NEXT.
REQ-024 tx_pronto outside WAIT SHALL be ignored.
REQ-025 NEXT: index=7 -> DONE; otherwise increment the index -> SEND.
REQ-026 DONE: fim=1 for one cycle -> IDLE.
REQ-027 ERR: erro=1 for one cycle -> IDLE; the remaining characters SHALL NOT be sent.
REQ-028 start SHALL be ignored in all states except IDLE; a start held high in the DONE or ERR cycle SHALL begin a new frame one cycle after the return to IDLE.
REQ-029 Latency: start sampled at edge k -> tx_partida high in cycle k+2. With tx_pronto one cycle after each partida, a frame SHALL take 1+8x3+1 = 26 cycles from LOAD to the return to IDLE.
REQ-030 The timeout counter SHALL be wide enough for TIMEOUT_CYCLES and SHALL NOT wrap before the timeout fires.

Reset
REQ-031 reset=1 at a clock edge SHALL force IDLE, index=0, counter=0, latched registers=0, tx_partida=0, fim=0, erro=0, ocupado=0, tx_dado=0x30, db_estado=0, in any state including mid-frame.
REQ-032 After mid-frame reset, no further tx_partida SHALL occur until a new start.

Verification
REQ-033 angulo=0x090, medida=0x123, start pulse, immediate tx_pronto responder -> characters "090,123#" (0x30,0x39,0x30,0x2C,0x31,0x32,0x33,0x23), 8 partida pulses, one fim pulse, erro=0.
REQ-034 TIMEOUT_CYCLES=10, no tx_pronto -> erro pulse exactly 10 cycles after entering WAIT for index 0, one partida total, then IDLE.
REQ-035 Change angulo/medida during transmission -> the frame still carries the values latched at LOAD.
REQ-036 Assert reset while WAIT is active for index 4 -> IDLE next cycle, all outputs at reset values, no partida until the next start.
REQ-037 medida=0x1A5 -> fifth through seventh characters '1','?','5'; start asserted while ocupado=1 -> no second frame begins.
REQ-038 TIMEOUT_CYCLES=10, tx_pronto arrives on the 10th WAIT cycle -> NEXT taken, no erro.
